// File: rtl/regfile_if.sv
// Register-file access bus: two operand read ports and one writeback port.
// The decode/writeback side is the master; the register file is the slave.
interface regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] readreg1;
    logic [ADDR_WIDTH-1:0] readreg2;
    logic [ADDR_WIDTH-1:0] writereg;
    logic [DATA_WIDTH-1:0] writedata;
    logic                  regwrite;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;

    modport master (
        output readreg1, readreg2, writereg, writedata, regwrite,
        input  read_data1, read_data2
    );

    modport slave (
        input  readreg1, readreg2, writereg, writedata, regwrite,
        output read_data1, read_data2
    );
endinterface

// File: rtl/regfile_32x32.sv
// 32 x 32-bit register file: two combinational read ports with write-through
// bypass, one synchronous write port, register 0 hardwired to zero.
module regfile_32x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
    input logic      clk,
    input logic      rst_n,
    regfile_if.slave rf
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wr_live;

    // A write is only real for a nonzero destination; register 0 stays zero.
    assign wr_live = rf.regwrite && (rf.writereg != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[rf.writereg] <= rf.writedata;
        end
    end

    // Reset forces zero and kills the bypass; otherwise the in-flight write
    // wins over the stored value so decode sees writeback's result this cycle.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic                  live,
        input logic [ADDR_WIDTH-1:0] idx,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  wr_en,
        input logic [ADDR_WIDTH-1:0] wr_idx,
        input logic [DATA_WIDTH-1:0] wr_data
    );
        logic [DATA_WIDTH-1:0] val;
        val = stored;
        if (!live || idx == '0) begin
            val = '0;
        end else if (wr_en && wr_idx == idx) begin
            val = wr_data;
        end
        return val;
    endfunction

    always_comb begin
        rf.read_data1 = read_port(rst_n, rf.readreg1, regs[rf.readreg1],
                                  wr_live, rf.writereg, rf.writedata);
    end

    always_comb begin
        rf.read_data2 = read_port(rst_n, rf.readreg2, regs[rf.readreg2],
                                  wr_live, rf.writereg, rf.writedata);
    end

endmodule

// File: tb/tb_regfile_32x32.sv
// Directed bench for regfile_32x32: literal checks plus a per-cycle
// comparison of both read ports against an array model of the register file.
module tb_regfile_32x32;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;
    bit   cmp_en;

    logic [31:0] model [32];

    regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf_bus ();

    regfile_32x32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: registers are just an array; reset wipes it, writes to r0 vanish.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (rf_bus.regwrite && rf_bus.writereg != 5'd0) begin
            model[rf_bus.writereg] = rf_bus.writedata;
        end
    end

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (!rst_n || idx == 5'd0) return 32'd0;
        if (rf_bus.regwrite && rf_bus.writereg == idx) return rf_bus.writedata;
        return model[idx];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_rd1", rf_bus.read_data1, exp_read(rf_bus.readreg1));
            check("model_rd2", rf_bus.read_data2, exp_read(rf_bus.readreg2));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        rf_bus.regwrite  = we;
        rf_bus.writereg  = wr;
        rf_bus.writedata = wd;
        rf_bus.readreg1  = r1;
        rf_bus.readreg2  = r2;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        cmp_en  = 1'b0;
        rst_n   = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;

        // Reset read
        check("reset_rd1_low", rf_bus.read_data1, 32'd0);
        check("reset_rd2_low", rf_bus.read_data2, 32'd0);
        step();
        rst_n = 1'b1;
        #10;
        check("reset_rd1_after", rf_bus.read_data1, 32'd0);
        check("reset_rd2_after", rf_bus.read_data2, 32'd0);

        // Write then read
        step();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
        step();
        drive(1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6);
        #1;
        check("write_r5", rf_bus.read_data1, 32'hDEADBEEF);
        check("unwritten_r6", rf_bus.read_data2, 32'd0);

        // Register 0 protection
        step();
        drive(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5);
        #1;
        check("r0_during_write", rf_bus.read_data1, 32'd0);
        step();
        drive(1'b0, 5'd0, 32'h12345678, 5'd0, 5'd5);
        #1;
        check("r0_after_write", rf_bus.read_data1, 32'd0);

        // Bypass on both ports, then stored value
        step();
        drive(1'b1, 5'd7, 32'd42, 5'd7, 5'd7);
        #1;
        check("bypass_rd1", rf_bus.read_data1, 32'd42);
        check("bypass_rd2", rf_bus.read_data2, 32'd42);
        step();
        drive(1'b0, 5'd7, 32'd42, 5'd7, 5'd7);
        #1;
        check("stored_rd1", rf_bus.read_data1, 32'd42);
        check("stored_rd2", rf_bus.read_data2, 32'd42);

        // Bypass is per port: only port 2 matches writereg
        step();
        drive(1'b1, 5'd5, 32'h0000_1111, 5'd7, 5'd5);
        #1;
        check("bypass_port2_only_rd1", rf_bus.read_data1, 32'd42);
        check("bypass_port2_only_rd2", rf_bus.read_data2, 32'h0000_1111);

        // Write disabled
        step();
        drive(1'b1, 5'd3, 32'd9, 5'd3, 5'd0);
        step();
        drive(1'b0, 5'd3, 32'd100, 5'd3, 5'd0);
        step();
        #1;
        check("write_disabled_r3", rf_bus.read_data1, 32'd9);

        // Fill 1..31 with their own index
        for (int i = 1; i < 32; i++) begin
            step();
            drive(1'b1, 5'(i), 32'(i), 5'd1, 5'd2);
        end
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd31, 5'd17);
        #1;
        check("fill_r31", rf_bus.read_data1, 32'd31);
        check("fill_r17", rf_bus.read_data2, 32'd17);

        // Async reset between edges
        step();
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_rd1", rf_bus.read_data1, 32'd0);
        check("async_rst_rd2", rf_bus.read_data2, 32'd0);
        drive(1'b1, 5'd31, 32'h5, 5'd31, 5'd31);
        #1;
        check("rst_no_bypass", rf_bus.read_data1, 32'd0);
        step();
        drive(1'b0, 5'd31, 32'h5, 5'd31, 5'd17);
        rst_n = 1'b1;
        #1;
        check("rst_write_ignored_r31", rf_bus.read_data1, 32'd0);
        check("rst_cleared_r17", rf_bus.read_data2, 32'd0);

        // First edge after release performs a write
        drive(1'b1, 5'd9, 32'h0000_00AA, 5'd1, 5'd2);
        step();
        drive(1'b0, 5'd9, 32'h0000_00AA, 5'd9, 5'd31);
        #1;
        check("post_rst_write_r9", rf_bus.read_data1, 32'h0000_00AA);
        check("post_rst_r31", rf_bus.read_data2, 32'd0);

        step();
        step();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
